// File: rtl/bus_arbiter.sv
// Round-robin owner arbitration for the shared serial bus.
// One master owns the bus at a time; a master that holds it too long
// (with the addressed slave not stretching) is revoked and blocked until
// it drops its request once.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | bus free; grant the next eligible master unless slave_busy
//   OWN   | one master owns the bus; watch for release or hold timeout
//   TURN  | single dead cycle after any release/revoke before next grant
module bus_arbiter #(
    parameter int NUM_MASTERS  = 3,
    parameter int HOLD_TIMEOUT = 256,
    parameter int ID_W         = ($clog2(NUM_MASTERS) > 1) ? $clog2(NUM_MASTERS) : 1,
    parameter int CNT_W        = $clog2(HOLD_TIMEOUT)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NUM_MASTERS-1:0] mreq,
    input  logic                   slave_busy,
    output logic [NUM_MASTERS-1:0] mgrant,
    output logic                   bus_util,
    output logic [ID_W-1:0]        grant_id,
    output logic                   timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(HOLD_TIMEOUT - 1);
    localparam logic [ID_W-1:0]  LAST_IDX = ID_W'(NUM_MASTERS - 1);

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] mgrant_q, mgrant_d;
    logic                   util_q, util_d;
    logic [ID_W-1:0]        grant_id_q, grant_id_d;
    logic                   terr_q, terr_d;
    logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]       hold_cnt_q, hold_cnt_d;
    logic [NUM_MASTERS-1:0] blocked_q, blocked_d;

    logic [NUM_MASTERS-1:0] eligible;
    logic                   sel_found;
    logic [ID_W-1:0]        sel_id;
    int                     sel_idx;
    logic                   owner_req;
    logic [ID_W-1:0]        next_ptr;

    assign eligible  = mreq & ~blocked_q;
    // mgrant_q is one-hot while owning, so this is the owner's request line.
    assign owner_req = |(mreq & mgrant_q);
    assign next_ptr  = (grant_id_q == LAST_IDX) ? '0 : grant_id_q + 1'b1;

    // First eligible master at or after rr_ptr, wrapping around.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        sel_idx   = 0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            sel_idx = (int'(rr_ptr_q) + k) % NUM_MASTERS;
            if (!sel_found && eligible[sel_idx]) begin
                sel_found = 1'b1;
                sel_id    = ID_W'(sel_idx);
            end
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d    = state_q;
        mgrant_d   = mgrant_q;
        util_d     = util_q;
        grant_id_d = grant_id_q;
        terr_d     = 1'b0;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        // A dropped request always clears the timeout block for that master.
        blocked_d  = blocked_q & mreq;

        case (state_q)
            IDLE: begin
                mgrant_d = '0;
                util_d   = 1'b0;
                if (sel_found && !slave_busy) begin
                    mgrant_d   = NUM_MASTERS'(1) << sel_id;
                    util_d     = 1'b1;
                    grant_id_d = sel_id;
                    hold_cnt_d = '0;
                    state_d    = OWN;
                end
            end
            OWN: begin
                if (!owner_req) begin
                    // Release takes priority over a coincident timeout.
                    mgrant_d = '0;
                    util_d   = 1'b0;
                    rr_ptr_d = next_ptr;
                    state_d  = TURN;
                end else if (!slave_busy) begin
                    if (hold_cnt_q == CNT_MAX) begin
                        mgrant_d  = '0;
                        util_d    = 1'b0;
                        terr_d    = 1'b1;
                        blocked_d = blocked_d | mgrant_q;
                        rr_ptr_d  = next_ptr;
                        state_d   = TURN;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
            end
            TURN: begin
                mgrant_d = '0;
                util_d   = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                mgrant_d = '0;
                util_d   = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any grant immediately.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            mgrant_q   <= '0;
            util_q     <= 1'b0;
            grant_id_q <= '0;
            terr_q     <= 1'b0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
            blocked_q  <= '0;
        end else begin
            state_q    <= state_d;
            mgrant_q   <= mgrant_d;
            util_q     <= util_d;
            grant_id_q <= grant_id_d;
            terr_q     <= terr_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            blocked_q  <= blocked_d;
        end
    end

    assign mgrant      = mgrant_q;
    assign bus_util    = util_q;
    assign grant_id    = grant_id_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: cycle model of ownership rules plus directed scenarios.
module tb_bus_arbiter;

    localparam int N   = 3;
    localparam int HT  = 8;
    localparam int IDW = 2;
    localparam int CW  = 3;

    logic         clk = 1'b0;
    logic         rstn = 1'b1;
    logic [N-1:0] mreq = '0;
    logic         slave_busy = 1'b0;
    logic [N-1:0] mgrant;
    logic         bus_util;
    logic [IDW-1:0] grant_id;
    logic         timeout_err;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    bus_arbiter #(
        .NUM_MASTERS (N),
        .HOLD_TIMEOUT(HT),
        .ID_W        (IDW),
        .CNT_W       (CW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .mreq       (mreq),
        .slave_busy (slave_busy),
        .mgrant     (mgrant),
        .bus_util   (bus_util),
        .grant_id   (grant_id),
        .timeout_err(timeout_err)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: owner index (-1 = none), owned-cycle count, dead cycles left,
    // next search start, per-master timeout block.
    int m_own = -1;
    int m_held = 0;
    int m_gap = 0;
    int m_ptr = 0;
    int m_id = 0;
    bit m_terr = 1'b0;
    bit m_blk[N];
    bit m_nb[N];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_own = -1; m_held = 0; m_gap = 0; m_ptr = 0; m_id = 0; m_terr = 1'b0;
            for (int i = 0; i < N; i++) m_blk[i] = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) m_nb[i] = m_blk[i] && mreq[i];
            m_terr = 1'b0;
            if (m_own >= 0) begin
                if (!mreq[m_own]) begin
                    m_ptr = (m_own + 1) % N; m_own = -1; m_gap = 1;
                end else if (!slave_busy) begin
                    if (m_held == HT) begin
                        m_terr = 1'b1; m_nb[m_own] = 1'b1;
                        m_ptr = (m_own + 1) % N; m_own = -1; m_gap = 1;
                    end else begin
                        m_held++;
                    end
                end
            end else if (m_gap > 0) begin
                m_gap--;
            end else if (!slave_busy) begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_ptr + k) % N;
                    if (m_own < 0 && mreq[c] && !m_blk[c]) begin
                        m_own = c; m_held = 1; m_id = c;
                    end
                end
            end
            for (int i = 0; i < N; i++) m_blk[i] = m_nb[i];
        end
    end

    logic [N-1:0] m_exp_grant;
    always @(negedge clk) begin
        if (cmp_en) begin
            m_exp_grant = (m_own >= 0) ? N'(1 << m_own) : '0;
            check("model_mgrant", mgrant, m_exp_grant);
            check("model_bus_util", bus_util, (m_own >= 0) ? 1 : 0);
            check("model_grant_id", grant_id, m_id);
            check("model_timeout_err", timeout_err, m_terr);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        #2 rstn = 1'b0;
        cyc(1);
        #2 rstn = 1'b1;
        cyc(1);
    endtask

    // Waits up to budget cycles for any grant, then checks which one it is.
    task automatic wait_grant(input string nm, input logic [N-1:0] exp, input int budget);
        int n;
        n = 0;
        while (mgrant == '0 && n < budget) begin
            cyc(1);
            n++;
        end
        check(nm, mgrant, exp);
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int order[$];
        int exp_order[4];
        int owned, zeros, bad;

        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 0;

        // Reset values
        #2 rstn = 1'b0;
        cyc(1);
        check("rst_mgrant", mgrant, 0);
        check("rst_bus_util", bus_util, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_timeout_err", timeout_err, 0);
        #2 rstn = 1'b1;
        cyc(1);
        cmp_en = 1'b1;

        // T1: reset in the middle of ownership drops the grant immediately
        mreq = 3'b010;
        wait_grant("t1_grant", 3'b010, 6);
        cyc(2);
        @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        check("t1_async_mgrant", mgrant, 0);
        check("t1_async_bus_util", bus_util, 0);
        check("t1_async_grant_id", grant_id, 0);
        mreq = '0;
        cyc(1);
        #2 rstn = 1'b1;
        cyc(1);

        // T2: single master, request c0, drop c5
        mreq = 3'b010;
        cyc(1);
        check("t2_c1_mgrant", mgrant, 3'b010);
        check("t2_c1_bus_util", bus_util, 1);
        cyc(4);
        check("t2_c5_mgrant", mgrant, 3'b010);
        mreq = '0;
        cyc(1);
        check("t2_c6_mgrant", mgrant, 0);
        check("t2_c6_bus_util", bus_util, 0);
        check("t2_c6_grant_id", grant_id, 1);
        cyc(3);
        check("t2_id_held", grant_id, 1);

        // T3: round robin with all requesting, each owner drops after 3 cycles
        do_reset();
        mreq = 3'b111;
        owned = 0;
        zeros = 0;
        for (int c = 0; c < 80 && order.size() < 4; c++) begin
            cyc(1);
            if (mgrant != '0) begin
                if (owned == 0) begin
                    order.push_back(onehot_idx(mgrant));
                    if (order.size() > 1) check("t3_gap_nonzero", (zeros >= 1) ? 1 : 0, 1);
                    zeros = 0;
                end
                owned++;
                if (owned == 3) mreq = 3'b111 & ~mgrant;
            end else begin
                owned = 0;
                zeros++;
                mreq = 3'b111;
            end
        end
        check("t3_grant_count", order.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < order.size()) check("t3_order", order[i], exp_order[i]);
        end
        mreq = '0;
        cyc(4);

        // T4: timeout revoke, then blocked until request drops once
        do_reset();
        mreq = 3'b011;
        wait_grant("t4_first_grant", 3'b001, 6);
        owned = 1;
        for (int c = 0; c < 30; c++) begin
            cyc(1);
            if (mgrant == '0) break;
            owned++;
        end
        check("t4_owned_cycles", owned, 8);
        check("t4_terr_pulse", timeout_err, 1);
        cyc(1);
        check("t4_terr_one_cycle", timeout_err, 0);
        wait_grant("t4_master1_next", 3'b010, 10);
        cyc(1);
        mreq = 3'b001;
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            cyc(1);
            if (mgrant != '0) bad++;
        end
        check("t4_blocked_no_regrant", bad, 0);
        mreq = 3'b000;
        cyc(1);
        mreq = 3'b001;
        wait_grant("t4_regrant_after_drop", 3'b001, 10);
        mreq = '0;
        cyc(3);

        // T5: slave stretching during ownership and in idle
        do_reset();
        mreq = 3'b001;
        wait_grant("t5_grant", 3'b001, 6);
        slave_busy = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            cyc(1);
            if (timeout_err || mgrant != 3'b001) bad++;
        end
        check("t5_stretch_kept", bad, 0);
        slave_busy = 1'b0;
        mreq = '0;
        cyc(3);
        slave_busy = 1'b1;
        mreq = 3'b001;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            cyc(1);
            if (mgrant != '0) bad++;
        end
        check("t5_idle_busy_blocks", bad, 0);
        slave_busy = 1'b0;
        cyc(1);
        check("t5_grant_after_busy", mgrant, 3'b001);
        mreq = '0;
        cyc(3);

        // T6: release on the same edge the timeout would fire
        do_reset();
        mreq = 3'b001;
        wait_grant("t6_grant", 3'b001, 6);
        cyc(7);
        check("t6_still_owned", mgrant, 3'b001);
        mreq = '0;
        cyc(1);
        check("t6_no_terr", timeout_err, 0);
        check("t6_released", mgrant, 0);
        mreq = 3'b001;
        wait_grant("t6_not_blocked", 3'b001, 6);
        mreq = '0;
        cyc(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
